instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 SHALL have parameter LAST_OP, default 5'h12, highest legal opcode.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load session.
REQ-006 base_addr  input  ADDR_W  first memory address of the session, sampled on accepted start.
REQ-007 count  input  ADDR_W  number of instructions in the session, sampled on accepted start.
REQ-008 in_valid  input  1  field bundle valid.
REQ-009 in_ready  output  1  encoder can accept a bundle this cycle.
REQ-010 in_op / in_mode / in_src / in_dst / in_lit  input  5/2/5/5/32  instruction fields.
REQ-011 mem_we  output  1  instruction-memory write strobe.
REQ-012 mem_addr  output  ADDR_W  write address.
REQ-013 mem_wdata  output  49  encoded instruction word.
REQ-014 busy  output  1  session in progress.
REQ-015 done  output  1  one-cycle session-complete pulse.
REQ-016 err  output  1  sticky illegal-opcode flag.
REQ-017 branch_cnt / store_cnt  output  ADDR_W each  branch / store instructions written this session.

Function
REQ-018 SHALL pack mem_wdata as op[48:44], mode[43:42], src[41:37], dst[36:32], lit[31:0].
REQ-019 SHALL classify op 5'h10, 5'h11, 5'h12 as branch and op 5'h02 as store.
REQ-020 SHALL implement states IDLE, LOAD, DONE.
REQ-021 IDLE: start=1 -> LOAD if count!=0, else DONE; SHALL latch base_addr, count; SHALL clear err, branch_cnt, store_cnt, index.
REQ-022 start SHALL be ignored in LOAD and DONE.
REQ-023 in_ready SHALL be 1 only in LOAD; a bundle transfers on a rising edge with in_valid=1 and in_ready=1.
REQ-024 Legal bundle (in_op<=LAST_OP) accepted at edge N SHALL give mem_we=1, mem_addr=(base+index) mod 2^ADDR_W, mem_wdata=encoded word for exactly the cycle after edge N; latency 1 cycle.
REQ-025 On each legal transfer, index SHALL increment; branch_cnt or store_cnt SHALL increment if classified.
REQ-026 Transfer making index equal count SHALL move LOAD -> DONE.
REQ-027 Illegal bundle (in_op>LAST_OP) SHALL not be written; SHALL set err=1; SHALL move LOAD -> DONE; later bundles in the session are not accepted.
REQ-028 mem_we SHALL be 0 in every cycle without a write from REQ-024; no write SHALL occur on a cycle with in_valid=0.
REQ-029 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-030 busy SHALL be 1 in LOAD and DONE, 0 in IDLE.
REQ-031 err, branch_cnt, store_cnt SHALL hold their values in IDLE until the next accepted start.
REQ-032 Address wrap: base+index exceeding 2^ADDR_W-1 SHALL wrap to 0 without error.

Reset
REQ-033 rst_n=0 SHALL immediately force state IDLE and in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, branch_cnt, store_cnt, index to 0.
REQ-034 Reset during LOAD SHALL abort the session; no write SHALL occur after rst_n falls; after rst_n=1 the block SHALL wait for a new start.

Verification
REQ-035 start, base=8'h10, count=3, bundles (op 00,01,02; lit 1,2,3) -> writes to 10,11,12 one cycle after each transfer; done pulses once; store_cnt=1, branch_cnt=0, err=0.
REQ-036 start, count=0 -> no mem_we; done=1 the cycle after start; busy=1 for that single cycle only.
REQ-037 start, base=8'hFE, count=3, ops 10,11,12 -> writes to FE, FF, 00; branch_cnt=3.
REQ-038 start, count=4; second bundle op=5'h13 -> one write only; err=1; done pulses; in_ready=0 afterwards; err holds in IDLE.
REQ-039 in_valid toggled 1,0,0,1 during LOAD -> writes only after valid cycles; addresses consecutive; start asserted in LOAD ignored.
REQ-040 rst_n low mid-session after 2 of 5 writes -> all outputs 0 at once; no further mem_we; new start with count=1 completes normally.

Source files
------------

// File: rtl/instr_encoder_if.sv
// Load-session bus for instr_encoder: session control, field bundle handshake,
// instruction-memory write port and session status.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] count;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [1:0]        in_mode;
    logic [4:0]        in_src;
    logic [4:0]        in_dst;
    logic [31:0]       in_lit;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [48:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] branch_cnt;
    logic [ADDR_W-1:0] store_cnt;

    modport master (
        output start, base_addr, count, in_valid, in_op, in_mode, in_src, in_dst, in_lit,
        input  in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, branch_cnt, store_cnt
    );

    modport slave (
        input  start, base_addr, count, in_valid, in_op, in_mode, in_src, in_dst, in_lit,
        output in_ready, mem_we, mem_addr, mem_wdata, busy, done, err, branch_cnt, store_cnt
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs instruction field bundles into 49-bit words and writes them to a
// contiguous instruction-memory region, one session per accepted start.
module instr_encoder #(
    parameter int unsigned ADDR_W  = 8,
    parameter logic [4:0]  LAST_OP = 5'h12
) (
    input logic            clk,
    input logic            rst_n,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] index;

    logic [ADDR_W-1:0] index_nxt_c;
    logic              xfer_c;
    logic              legal_c;
    logic              is_branch_c;
    logic              is_store_c;

    // Transfer qualification and opcode classification of the presented bundle
    always_comb begin
        index_nxt_c = index + ADDR_W'(1);
        xfer_c      = (state == LOAD) && bus.in_valid && bus.in_ready;
        legal_c     = (bus.in_op <= LAST_OP);
        is_branch_c = (bus.in_op == 5'h10) || (bus.in_op == 5'h11) || (bus.in_op == 5'h12);
        is_store_c  = (bus.in_op == 5'h02);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            base_q         <= '0;
            count_q        <= '0;
            index          <= '0;
            bus.in_ready   <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
            bus.branch_cnt <= '0;
            bus.store_cnt  <= '0;
        end else begin
            bus.mem_we <= 1'b0;
            bus.done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base_q         <= bus.base_addr;
                        count_q        <= bus.count;
                        index          <= '0;
                        bus.err        <= 1'b0;
                        bus.branch_cnt <= '0;
                        bus.store_cnt  <= '0;
                        bus.busy       <= 1'b1;
                        if (bus.count != '0) begin
                            state        <= LOAD;
                            bus.in_ready <= 1'b1;
                        end else begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer_c) begin
                        if (legal_c) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= base_q + index;
                            bus.mem_wdata <= {bus.in_op, bus.in_mode, bus.in_src,
                                              bus.in_dst, bus.in_lit};
                            index         <= index_nxt_c;
                            if (is_branch_c) bus.branch_cnt <= bus.branch_cnt + ADDR_W'(1);
                            if (is_store_c)  bus.store_cnt  <= bus.store_cnt + ADDR_W'(1);
                            if (index_nxt_c == count_q) begin
                                state        <= DONE;
                                bus.in_ready <= 1'b0;
                                bus.done     <= 1'b1;
                            end
                        end else begin
                            // Illegal opcode ends the session without a write
                            bus.err      <= 1'b1;
                            state        <= DONE;
                            bus.in_ready <= 1'b0;
                            bus.done     <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule
